// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest commit buffer.
// The record struct documents the field layout packed into the FIFO payload.
package difftest_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned NR_GPR       = 32;
   localparam int unsigned RD_W         = 5;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic                    wen;
      logic [RD_W-1:0]         rd;
      logic [XLEN_DEFAULT-1:0] wdata;
   } commit_rec_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } out_state_e;

   // Payload width of one record, {pc, wen, rd, wdata}, for a given XLEN.
   function automatic int unsigned rec_width(input int unsigned xlen);
      return 2 * xlen + 1 + RD_W;
   endfunction

endpackage

// File: rtl/difftest_commit_buffer_fifo.sv
// Synchronous FIFO holding retired-instruction records.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module commit_fifo
   import difftest_pkg::*;
#(
   parameter int unsigned WIDTH = 70,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/difftest_commit_buffer.sv
// Buffers retired instructions and presents one shadow-register-file
// snapshot per commit to a difftest consumer with valid/ready handshaking.
module difftest_commit_buffer
   import difftest_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmt_valid,
   output logic            cmt_ready,
   input  logic [XLEN-1:0] cmt_pc,
   input  logic            cmt_wen,
   input  logic [4:0]      cmt_rd,
   input  logic [XLEN-1:0] cmt_wdata,
   output logic            dt_valid,
   input  logic            dt_ready,
   output logic [XLEN-1:0] dt_pc,
   output logic [XLEN-1:0] dt_rf_0,
   output logic [XLEN-1:0] dt_rf_1,
   output logic [XLEN-1:0] dt_rf_2,
   output logic [XLEN-1:0] dt_rf_3,
   output logic [XLEN-1:0] dt_rf_4,
   output logic [XLEN-1:0] dt_rf_5,
   output logic [XLEN-1:0] dt_rf_6,
   output logic [XLEN-1:0] dt_rf_7,
   output logic [XLEN-1:0] dt_rf_8,
   output logic [XLEN-1:0] dt_rf_9,
   output logic [XLEN-1:0] dt_rf_10,
   output logic [XLEN-1:0] dt_rf_11,
   output logic [XLEN-1:0] dt_rf_12,
   output logic [XLEN-1:0] dt_rf_13,
   output logic [XLEN-1:0] dt_rf_14,
   output logic [XLEN-1:0] dt_rf_15,
   output logic [XLEN-1:0] dt_rf_16,
   output logic [XLEN-1:0] dt_rf_17,
   output logic [XLEN-1:0] dt_rf_18,
   output logic [XLEN-1:0] dt_rf_19,
   output logic [XLEN-1:0] dt_rf_20,
   output logic [XLEN-1:0] dt_rf_21,
   output logic [XLEN-1:0] dt_rf_22,
   output logic [XLEN-1:0] dt_rf_23,
   output logic [XLEN-1:0] dt_rf_24,
   output logic [XLEN-1:0] dt_rf_25,
   output logic [XLEN-1:0] dt_rf_26,
   output logic [XLEN-1:0] dt_rf_27,
   output logic [XLEN-1:0] dt_rf_28,
   output logic [XLEN-1:0] dt_rf_29,
   output logic [XLEN-1:0] dt_rf_30,
   output logic [XLEN-1:0] dt_rf_31,
   output logic [31:0]     dt_seq
);

   localparam int unsigned REC_W = rec_width(XLEN);

   out_state_e       r_state;
   out_state_e       w_state_nxt;
   logic [XLEN-1:0]  r_dt_pc;
   logic [XLEN-1:0]  r_rf [1:NR_GPR-1];
   logic [31:0]      r_seq;

   logic [REC_W-1:0] w_push_data;
   logic [REC_W-1:0] w_head;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_hs;
   logic [XLEN-1:0]  w_head_pc;
   logic             w_head_wen;
   logic [4:0]       w_head_rd;
   logic [XLEN-1:0]  w_head_wdata;

   assign cmt_ready   = !w_fifo_full;
   assign w_push      = cmt_valid && cmt_ready;
   assign w_push_data = {cmt_pc, cmt_wen, cmt_rd, cmt_wdata};

   assign w_head_pc    = w_head[REC_W-1 -: XLEN];
   assign w_head_wen   = w_head[XLEN + RD_W];
   assign w_head_rd    = w_head[XLEN +: RD_W];
   assign w_head_wdata = w_head[XLEN-1:0];

   // A new head is loaded when the output slot is empty or being vacated.
   assign w_hs  = dt_valid && dt_ready;
   assign w_pop = !w_fifo_empty && ((r_state == ST_IDLE) || dt_ready);

   commit_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_push_data),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (!w_fifo_empty) w_state_nxt = ST_HOLD;
         ST_HOLD: if (dt_ready && w_fifo_empty) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      dt_valid = 1'b0;
      case (r_state)
         ST_HOLD: dt_valid = 1'b1;
         default: dt_valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dt_pc <= '0;
         r_seq   <= '0;
         for (int unsigned i = 1; i < NR_GPR; i++) r_rf[i] <= '0;
      end else begin
         if (w_pop) begin
            r_dt_pc <= w_head_pc;
            if (w_head_wen && (w_head_rd != '0)) r_rf[w_head_rd] <= w_head_wdata;
         end
         if (w_hs) r_seq <= r_seq + 32'd1;
      end
   end

   assign dt_pc    = r_dt_pc;
   assign dt_seq   = r_seq;
   assign dt_rf_0  = '0;
   assign dt_rf_1  = r_rf[1];
   assign dt_rf_2  = r_rf[2];
   assign dt_rf_3  = r_rf[3];
   assign dt_rf_4  = r_rf[4];
   assign dt_rf_5  = r_rf[5];
   assign dt_rf_6  = r_rf[6];
   assign dt_rf_7  = r_rf[7];
   assign dt_rf_8  = r_rf[8];
   assign dt_rf_9  = r_rf[9];
   assign dt_rf_10 = r_rf[10];
   assign dt_rf_11 = r_rf[11];
   assign dt_rf_12 = r_rf[12];
   assign dt_rf_13 = r_rf[13];
   assign dt_rf_14 = r_rf[14];
   assign dt_rf_15 = r_rf[15];
   assign dt_rf_16 = r_rf[16];
   assign dt_rf_17 = r_rf[17];
   assign dt_rf_18 = r_rf[18];
   assign dt_rf_19 = r_rf[19];
   assign dt_rf_20 = r_rf[20];
   assign dt_rf_21 = r_rf[21];
   assign dt_rf_22 = r_rf[22];
   assign dt_rf_23 = r_rf[23];
   assign dt_rf_24 = r_rf[24];
   assign dt_rf_25 = r_rf[25];
   assign dt_rf_26 = r_rf[26];
   assign dt_rf_27 = r_rf[27];
   assign dt_rf_28 = r_rf[28];
   assign dt_rf_29 = r_rf[29];
   assign dt_rf_30 = r_rf[30];
   assign dt_rf_31 = r_rf[31];

endmodule

// File: tb/tb_difftest_commit_buffer.sv
// Scoreboard bench: expected snapshots are queued as commits are accepted
// and a negedge monitor checks every handshake and every stalled cycle.
module tb_difftest_commit_buffer;
   import difftest_pkg::*;

   typedef struct packed {
      logic [31:0]   pc;
      logic [1023:0] rf;
      logic [31:0]   seq;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmt_valid = 1'b0;
   logic        cmt_ready;
   logic [31:0] cmt_pc = '0;
   logic        cmt_wen = 1'b0;
   logic [4:0]  cmt_rd = '0;
   logic [31:0] cmt_wdata = '0;
   logic        dt_valid;
   logic        dt_ready = 1'b0;
   logic [31:0] dt_pc;
   logic [31:0] dt_seq;
   logic [31:0] rf [32];
   logic [1023:0] rf_flat;

   exp_t        sb[$];
   logic [31:0] m_rf [32];
   int unsigned m_seq = 0;
   int          total = 0;
   int          bad = 0;
   logic        done = 1'b0;

   always #5 clk = ~clk;

   always_comb begin
      rf_flat = '0;
      for (int k = 0; k < 32; k++) rf_flat[k*32 +: 32] = rf[k];
   end

   difftest_commit_buffer #(.DEPTH(4), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc),
      .cmt_wen(cmt_wen), .cmt_rd(cmt_rd), .cmt_wdata(cmt_wdata),
      .dt_valid(dt_valid), .dt_ready(dt_ready), .dt_pc(dt_pc),
      .dt_rf_0(rf[0]),   .dt_rf_1(rf[1]),   .dt_rf_2(rf[2]),   .dt_rf_3(rf[3]),
      .dt_rf_4(rf[4]),   .dt_rf_5(rf[5]),   .dt_rf_6(rf[6]),   .dt_rf_7(rf[7]),
      .dt_rf_8(rf[8]),   .dt_rf_9(rf[9]),   .dt_rf_10(rf[10]), .dt_rf_11(rf[11]),
      .dt_rf_12(rf[12]), .dt_rf_13(rf[13]), .dt_rf_14(rf[14]), .dt_rf_15(rf[15]),
      .dt_rf_16(rf[16]), .dt_rf_17(rf[17]), .dt_rf_18(rf[18]), .dt_rf_19(rf[19]),
      .dt_rf_20(rf[20]), .dt_rf_21(rf[21]), .dt_rf_22(rf[22]), .dt_rf_23(rf[23]),
      .dt_rf_24(rf[24]), .dt_rf_25(rf[25]), .dt_rf_26(rf[26]), .dt_rf_27(rf[27]),
      .dt_rf_28(rf[28]), .dt_rf_29(rf[29]), .dt_rf_30(rf[30]), .dt_rf_31(rf[31]),
      .dt_seq(dt_seq)
   );

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_rf(input string name, input logic [1023:0] exp);
      total++;
      if (rf_flat !== exp) begin
         bad++;
         for (int k = 0; k < 32; k++) begin
            if (rf_flat[k*32 +: 32] !== exp[k*32 +: 32]) begin
               $display("FAIL %s dt_rf_%0d: got %h expected %h", name, k,
                        rf_flat[k*32 +: 32], exp[k*32 +: 32]);
               break;
            end
         end
      end
   endtask

   function automatic commit_rec_t mk(input logic [31:0] pc, input logic wen,
                                      input logic [4:0] rd, input logic [31:0] wdata);
      commit_rec_t r;
      r.pc = pc; r.wen = wen; r.rd = rd; r.wdata = wdata;
      return r;
   endfunction

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic push(input commit_rec_t r);
      exp_t e;
      int   n = 0;
      cmt_pc = r.pc; cmt_wen = r.wen; cmt_rd = r.rd; cmt_wdata = r.wdata;
      cmt_valid = 1'b1;
      while (!cmt_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmt_ready) begin
         total++; bad++;
         $display("FAIL push_timeout: cmt_ready got 0 expected 1");
         cmt_valid = 1'b0;
         return;
      end
      if (r.wen && r.rd != 5'd0) m_rf[r.rd] = r.wdata;
      e.pc = r.pc;
      for (int k = 0; k < 32; k++) e.rf[k*32 +: 32] = m_rf[k];
      e.seq = m_seq;
      m_seq++;
      sb.push_back(e);
      @(posedge clk); #1;
      cmt_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      dt_ready = 1'b1;
      while ((sb.size() != 0 || dt_valid) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (sb.size() != 0 || dt_valid) begin
         bad++;
         $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
      end
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      cmt_valid = 1'b0;
      dt_ready = 1'b0;
      sb.delete();
      m_seq = 0;
      for (int k = 0; k < 32; k++) m_rf[k] = '0;
      #1;
      check32("rst_dt_valid", {31'b0, dt_valid}, 32'd0);
      check32("rst_dt_pc", dt_pc, 32'd0);
      check32("rst_dt_seq", dt_seq, 32'd0);
      check_rf("rst_rf", '0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check32("rst_cmt_ready", {31'b0, cmt_ready}, 32'd1);
   endtask

   // Monitor: checks each handshake against the scoreboard head, and that a
   // stalled snapshot is unchanged on the following cycle.
   initial begin
      exp_t          e;
      logic          stalled;
      logic [31:0]   s_pc;
      logic [1023:0] s_rf;
      stalled = 1'b0;
      s_pc = '0;
      s_rf = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               total++;
               if (!dt_valid || dt_pc !== s_pc || rf_flat !== s_rf) begin
                  bad++;
                  $display("FAIL stall_stable: got valid=%b pc=%h expected valid=1 pc=%h (rf equal=%b)",
                           dt_valid, dt_pc, s_pc, rf_flat === s_rf);
               end
            end
            stalled = 1'b0;
            if (dt_valid && dt_ready) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_snapshot: got pc=%h expected none", dt_pc);
               end else begin
                  e = sb.pop_front();
                  check32("hs_dt_pc", dt_pc, e.pc);
                  check_rf("hs_rf", e.rf);
                  check32("hs_dt_seq", dt_seq, e.seq);
               end
            end else if (dt_valid) begin
               stalled = 1'b1;
               s_pc = dt_pc;
               s_rf = rf_flat;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < 32; k++) m_rf[k] = '0;
      do_reset();

      // Single commit, latency and first snapshot
      dt_ready = 1'b1;
      push(mk(32'h8000_0000, 1'b1, 5'd5, 32'h1234_5678));
      @(negedge clk);
      check32("latency_e0", {31'b0, dt_valid}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check32("latency_e1", {31'b0, dt_valid}, 32'd1);
      check32("rf5_value", rf[5], 32'h1234_5678);
      @(posedge clk); #1;
      check32("seq_after_one", dt_seq, 32'd1);
      check32("idle_after_one", {31'b0, dt_valid}, 32'd0);

      // x0 never written; wen=0 leaves destination untouched
      push(mk(32'h8000_0004, 1'b1, 5'd3, 32'h0000_0033));
      push(mk(32'h8000_0008, 1'b1, 5'd0, 32'hFFFF_FFFF));
      push(mk(32'h8000_000C, 1'b0, 5'd3, 32'hDEAD_BEEF));
      drain();
      check32("rf0_zero", rf[0], 32'd0);
      check32("rf3_kept", rf[3], 32'h0000_0033);

      // Fill: one held in output plus DEPTH in FIFO, then back-to-back drain
      dt_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push(mk(32'h9000_0000 + 32'(i * 4), 1'b1, 5'(10 + i), 32'hC0DE_0000 + 32'(i)));
      check32("full_not_ready", {31'b0, cmt_ready}, 32'd0);
      cmt_pc = 32'h9000_0100; cmt_wen = 1'b1; cmt_rd = 5'd20; cmt_wdata = 32'h6666_6666;
      cmt_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check32("sixth_held_off", {31'b0, cmt_ready}, 32'd0);
      end
      cmt_valid = 1'b0;
      dt_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check32("b2b_valid", {31'b0, dt_valid}, 32'd1);
         @(posedge clk); #1;
      end
      check32("b2b_done", {31'b0, dt_valid}, 32'd0);

      // 100 commits under random backpressure
      do_reset();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++)
               push(mk(32'h0000_1000 + 32'(i * 4), (i % 3) != 0, 5'(i % 32),
                       32'(i) * 32'h0101_0101 ^ 32'h0000_00A5));
            done = 1'b1;
         end
         begin
            while (!done) begin
               dt_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
         end
      join
      drain();
      check32("seq_100", dt_seq, 32'd100);

      // Asynchronous reset with records queued discards them
      dt_ready = 1'b0;
      push(mk(32'hA000_0000, 1'b1, 5'd7, 32'h7777_7777));
      push(mk(32'hA000_0004, 1'b1, 5'd8, 32'h8888_8888));
      push(mk(32'hA000_0008, 1'b1, 5'd9, 32'h9999_9999));
      @(negedge clk);
      check32("queued_presented", {31'b0, dt_valid}, 32'd1);
      @(posedge clk); #1;
      do_reset();
      dt_ready = 1'b1;
      repeat (6) begin
         @(posedge clk); #1;
      end
      check32("no_stale_after_reset", {31'b0, dt_valid}, 32'd0);
      check32("seq_after_reset", dt_seq, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
